// File: rtl/pci_cfg_mv_if.sv
// Bus-side signals of pci_cfg_mv: config access strobe/response and the MSI message write handshake.
// msi_wr: a beat transfers on a clock edge where valid and ready are both 1; valid never drops before that edge, payload stays stable while valid.
interface pci_cfg_mv_if;
  logic        cfg_enable;
  logic        cfg_iswrite;
  logic [5:0]  cfg_offset;
  logic [3:0]  cfg_byte_en;
  logic [31:0] cfg_write_val;
  logic [31:0] cfg_read_val;
  logic        cfg_ack;
  logic        msi_wr_valid;
  logic        msi_wr_ready;
  logic [63:0] msi_wr_addr;
  logic [31:0] msi_wr_data;

  modport master (
    output cfg_enable, cfg_iswrite, cfg_offset, cfg_byte_en, cfg_write_val, msi_wr_ready,
    input  cfg_read_val, cfg_ack, msi_wr_valid, msi_wr_addr, msi_wr_data
  );

  modport slave (
    input  cfg_enable, cfg_iswrite, cfg_offset, cfg_byte_en, cfg_write_val, msi_wr_ready,
    output cfg_read_val, cfg_ack, msi_wr_valid, msi_wr_addr, msi_wr_data
  );
endinterface

// File: rtl/pci_cfg_mv.sv
// PCI type-0 config space: RO IDs, BARs, sticky RW1C status and a 64-bit multi-message MSI generator.
// Define PCI_MSI_PVM_EN to add MSI per-vector mask (0x14) and pending (0x15) registers.
module pci_cfg_mv #(
  parameter logic [15:0] VENDOR_ID         = 16'h1234,
  parameter logic [15:0] DEVICE_ID         = 16'h11e8,
  parameter logic [23:0] CLASS_CODE        = 24'hff0000,
  parameter logic [7:0]  REVISION          = 8'h10,
  parameter logic [15:0] SUBSYS_ID_DEF     = 16'h11e8,
  parameter logic [15:0] SUBSYS_VENDOR_DEF = 16'h1234,
  parameter int          NUM_BARS          = 1,
  parameter int          BAR_SIZE_LOG2     = 12,
  parameter int          MSI_MMC           = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  pci_cfg_mv_if.slave             bus,
  input  logic                    intr_status,
  input  logic                    ev_mdpe,
  input  logic                    ev_sta,
  input  logic                    ev_rta,
  input  logic                    ev_rma,
  input  logic                    ev_sse,
  input  logic                    ev_dpe,
  output logic [NUM_BARS*32-1:0]  bar_base,
  output logic                    mem_space_en,
  output logic                    bus_master_en,
  output logic                    intx_disable,
  output logic                    serr_en,
  output logic                    perr_resp,
  output logic                    msi_en,
  input  logic                    msi_req,
  input  logic [4:0]              msi_vector,
  output logic                    msi_accept,
  output logic                    msi_busy_dbg
);
  localparam logic [31:0] CMD_MASK  = 32'h0000_075f;
  localparam logic [31:0] LAT_MASK  = 32'h0000_f8ff;
  localparam logic [31:0] BAR_MASK  = 32'hffff_ffff << BAR_SIZE_LOG2;
  localparam logic [2:0]  MMC       = 3'(MSI_MMC);
  localparam logic [7:0]  STS_MASK  = 8'hf9;
`ifdef PCI_MSI_PVM_EN
  localparam logic [31:0] VEC_MASK  = (32'h1 << (1 << MSI_MMC)) - 32'h1;
  localparam logic        PVM       = 1'b1;
`else
  localparam logic        PVM       = 1'b0;
`endif

  typedef enum logic {IDLE, SEND} msi_state_t;

  logic [31:0] cmd_q, lat_q, subsys_q, intl_q, addr_lo_q, addr_hi_q, data_q;
  logic [31:0] bar_q [NUM_BARS];
  logic [7:0]  sts_q, ev, sts_clr;
  logic [2:0]  mme_q;
  logic        msi_en_q;
  logic [31:0] bm, rd_mux, bar_rd;
  logic        wr, eligible;
  logic [15:0] lo_mask;
  logic [4:0]  req_vec, send_vec;
  logic [31:0] msg_data;
  msi_state_t  state_q;

  function automatic logic [31:0] upd(input logic [31:0] old, input logic [31:0] nv,
                                      input logic [31:0] m);
    return (old & ~m) | (nv & m);
  endfunction

  assign wr = bus.cfg_enable & bus.cfg_iswrite;
  assign bm = {{8{bus.cfg_byte_en[3]}}, {8{bus.cfg_byte_en[2]}},
               {8{bus.cfg_byte_en[1]}}, {8{bus.cfg_byte_en[0]}}};
  assign ev = {ev_dpe, ev_sse, ev_rma, ev_rta, ev_sta, 2'b00, ev_mdpe};
  assign sts_clr = (wr && bus.cfg_offset == 6'h01 && bus.cfg_byte_en[3])
                   ? (bus.cfg_write_val[31:24] & STS_MASK) : 8'h00;

  assign mem_space_en  = cmd_q[1];
  assign bus_master_en = cmd_q[2];
  assign perr_resp     = cmd_q[6];
  assign serr_en       = cmd_q[8];
  assign intx_disable  = cmd_q[10];
  assign msi_en        = msi_en_q;
  assign eligible      = msi_en_q & cmd_q[2];
  assign msi_busy_dbg  = (state_q == SEND);

  for (genvar n = 0; n < NUM_BARS; n++) begin : g_bar
    assign bar_base[32*n +: 32] = bar_q[n];
  end

`ifdef PCI_MSI_PVM_EN
  logic [31:0] mask_q, pend_q, ready_v;
  logic [4:0]  pick_idx;
  logic        pick_any, pvm_go;
  assign ready_v = pend_q & ~mask_q & VEC_MASK;
  // Descending scan so the lowest pending, unmasked vector wins.
  always_comb begin
    pick_any = 1'b0;
    pick_idx = 5'd0;
    for (int i = 31; i >= 0; i--) begin
      if (ready_v[i]) begin
        pick_any = 1'b1;
        pick_idx = 5'(i);
      end
    end
  end
  assign pvm_go   = eligible & pick_any;
  assign send_vec = pvm_go ? pick_idx : req_vec;
`else
  assign send_vec = req_vec;
`endif

  assign lo_mask  = ~(16'hffff << mme_q);
  assign req_vec  = msi_vector & lo_mask[4:0];
  assign msg_data = {16'h0000, (data_q[15:0] & ~lo_mask) | ({11'h000, send_vec} & lo_mask)};

  always_comb begin
    bar_rd = 32'h0;
    for (int n = 0; n < NUM_BARS; n++)
      if (bus.cfg_offset == 6'(4 + n)) bar_rd = bar_q[n];
  end

  always_comb begin
    rd_mux = 32'h0;
    case (bus.cfg_offset)
      6'h00: rd_mux = {DEVICE_ID, VENDOR_ID};
      6'h01: rd_mux = {sts_q, 3'b000, 1'b1, intr_status, 3'b000, 16'h0000} | cmd_q;
      6'h02: rd_mux = {CLASS_CODE, REVISION};
      6'h03: rd_mux = lat_q;
      6'h04, 6'h05, 6'h06, 6'h07, 6'h08, 6'h09: rd_mux = bar_rd;
      6'h0b: rd_mux = subsys_q;
      6'h0d: rd_mux = 32'h0000_0040;
      6'h0f: rd_mux = 32'h0000_0100 | intl_q;
      6'h10: rd_mux = {7'h00, PVM, 1'b1, mme_q, MMC, msi_en_q, 8'h00, 8'h05};
      6'h11: rd_mux = addr_lo_q;
      6'h12: rd_mux = addr_hi_q;
      6'h13: rd_mux = data_q;
`ifdef PCI_MSI_PVM_EN
      6'h14: rd_mux = mask_q;
      6'h15: rd_mux = pend_q;
`endif
      default: rd_mux = 32'h0;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bus.cfg_ack      <= 1'b0;
      bus.cfg_read_val <= 32'h0;
      cmd_q            <= 32'h0;
      sts_q            <= 8'h00;
      lat_q            <= 32'h0;
      subsys_q         <= {SUBSYS_ID_DEF, SUBSYS_VENDOR_DEF};
      intl_q           <= 32'h0;
      mme_q            <= 3'd0;
      msi_en_q         <= 1'b0;
      addr_lo_q        <= 32'h0;
      addr_hi_q        <= 32'h0;
      data_q           <= 32'h0;
      for (int n = 0; n < NUM_BARS; n++) bar_q[n] <= 32'h0;
`ifdef PCI_MSI_PVM_EN
      mask_q           <= 32'h0;
`endif
    end else begin
      bus.cfg_ack <= bus.cfg_enable;
      if (bus.cfg_enable && !bus.cfg_iswrite) bus.cfg_read_val <= rd_mux;
      // A new event in the same cycle as its clear leaves the bit set.
      sts_q <= (sts_q & ~sts_clr) | ev;
      if (wr) begin
        case (bus.cfg_offset)
          6'h01: cmd_q     <= upd(cmd_q, bus.cfg_write_val, bm) & CMD_MASK;
          6'h03: lat_q     <= upd(lat_q, bus.cfg_write_val, bm) & LAT_MASK;
          6'h0b: subsys_q  <= upd(subsys_q, bus.cfg_write_val, bm);
          6'h0f: intl_q    <= upd(intl_q, bus.cfg_write_val, bm) & 32'h0000_00ff;
          6'h10: begin
            if (bus.cfg_byte_en[2]) begin
              msi_en_q <= bus.cfg_write_val[16];
              mme_q    <= (bus.cfg_write_val[22:20] > MMC) ? MMC : bus.cfg_write_val[22:20];
            end
          end
          6'h11: addr_lo_q <= upd(addr_lo_q, bus.cfg_write_val, bm) & 32'hffff_fffc;
          6'h12: addr_hi_q <= upd(addr_hi_q, bus.cfg_write_val, bm);
          6'h13: data_q    <= upd(data_q, bus.cfg_write_val, bm) & 32'h0000_ffff;
`ifdef PCI_MSI_PVM_EN
          6'h14: mask_q    <= upd(mask_q, bus.cfg_write_val, bm) & VEC_MASK;
`endif
          default: ;
        endcase
        for (int n = 0; n < NUM_BARS; n++)
          if (bus.cfg_offset == 6'(4 + n)) bar_q[n] <= upd(bar_q[n], bus.cfg_write_val, bm) & BAR_MASK;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q          <= IDLE;
      msi_accept       <= 1'b0;
      bus.msi_wr_valid <= 1'b0;
      bus.msi_wr_addr  <= 64'h0;
      bus.msi_wr_data  <= 32'h0;
`ifdef PCI_MSI_PVM_EN
      pend_q           <= 32'h0;
`endif
    end else begin
      msi_accept <= 1'b0;
      case (state_q)
        IDLE: begin
`ifdef PCI_MSI_PVM_EN
          if (pvm_go) begin
            pend_q[pick_idx] <= 1'b0;
            state_q          <= SEND;
            bus.msi_wr_valid <= 1'b1;
            bus.msi_wr_addr  <= {addr_hi_q, addr_lo_q};
            bus.msi_wr_data  <= msg_data;
          end else
`endif
          if (msi_req) begin
            msi_accept <= 1'b1;
            if (eligible) begin
`ifdef PCI_MSI_PVM_EN
              if (mask_q[req_vec]) pend_q[req_vec] <= 1'b1;
              else
`endif
              begin
                state_q          <= SEND;
                bus.msi_wr_valid <= 1'b1;
                bus.msi_wr_addr  <= {addr_hi_q, addr_lo_q};
                bus.msi_wr_data  <= msg_data;
              end
            end
          end
        end
        SEND: begin
          if (bus.msi_wr_ready) begin
            bus.msi_wr_valid <= 1'b0;
            state_q          <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule
